fifo_axi_burst_writer: RTL

- Sits directly downstream of the 32-bit async prefetch FIFO read port, in the DDR/AXI clock domain.
- Drains 32-bit pixel words with the FIFO's rd_en/rd_vld handshake and packs four words into each 128-bit beat.
- Issues fixed-length INCR AXI write bursts into a circular frame buffer region.
- Reports frame completion to the frame-control logic.

---
 rtl/fifo_axi_burst_pkg.sv | 33 +++
 rtl/fifo_word_packer_32to128.sv | 65 ++++++
 rtl/fifo_axi_burst_writer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fifo_axi_burst_pkg.sv
// Shared constants, FSM states and config helpers for the
// FIFO-to-AXI burst writer.
package fifo_axi_burst_pkg;

  localparam int unsigned BEAT_BYTES     = 16;
  localparam int unsigned WORDS_PER_BEAT = 4;
  localparam logic [2:0]  AXI_AWSIZE     = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    WB
  } state_e;

  function automatic logic [7:0] awlen_of(input int unsigned blen);
    return 8'(blen - 1);
  endfunction

  // Bursts must tile the frame exactly so the wrap compare can be
  // an equality test at a burst boundary.
  function automatic bit frame_cfg_ok(
    input longint unsigned base,
    input longint unsigned bytes,
    input longint unsigned blen
  );
    longint unsigned bb;
    bb = blen * BEAT_BYTES;
    return (blen >= 1) && (blen <= 256) && (bytes != 0) &&
           (base % bb == 0) && (bytes % bb == 0);
  endfunction

endpackage

// File: rtl/fifo_word_packer_32to128.sv
// Packs four 32-bit words into one 128-bit beat; first word lands
// in the low lane. A held beat is never overwritten.
module fifo_word_packer_32to128
  import fifo_axi_burst_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [127:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  localparam int unsigned ACC_W = 32 * (WORDS_PER_BEAT - 1);
  localparam logic [1:0]  LAST  = 2'(WORDS_PER_BEAT - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]       idx_q, idx_d;
  logic [127:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             accept;

  // The closing word may only enter if the held beat leaves now.
  assign in_ready_o  = !(idx_q == LAST && valid_q && !out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  // Accumulate words; the last one builds the beat directly.
  always_comb begin
    acc_d   = acc_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && out_ready_i) valid_d = 1'b0;
    if (accept) begin
      if (idx_q == LAST) begin
        data_d  = {in_data_i, acc_q};
        valid_d = 1'b1;
        idx_d   = '0;
      end else begin
        acc_d[32*idx_q +: 32] = in_data_i;
        idx_d = idx_q + 2'd1;
      end
    end
  end

  // Packer state; reset flushes any partial beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fifo_axi_burst_writer.sv
// Drains the prefetch FIFO into fixed-length INCR AXI write bursts
// over a circular frame buffer; pulses frame_done on wrap.
module fifo_axi_burst_writer
  import fifo_axi_burst_pkg::*;
#(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FRAME_BASE  = 0,
  parameter int unsigned FRAME_BYTES = 3686400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sof,
  output logic              rd_en,
  input  logic              rd_vld,
  input  logic [31:0]       rd_data,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [127:0]      m_wdata,
  output logic [15:0]       m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic              m_wlast,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int unsigned BURST_WORDS = BURST_LEN * WORDS_PER_BEAT;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W:0] ADDR_INC = (ADDR_W+1)'(BURST_BYTES);
  localparam logic [ADDR_W:0] END_ADDR =
    (ADDR_W+1)'(64'(FRAME_BASE) + 64'(FRAME_BYTES));
  localparam logic [8:0]  BEATS_INIT = 9'(BURST_LEN);
  localparam logic [10:0] WORDS_INIT = 11'(BURST_WORDS);

  if (!frame_cfg_ok(FRAME_BASE, FRAME_BYTES, BURST_LEN)) begin : g_cfg
    $error("fifo_axi_burst_writer: frame not burst-aligned");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        beat_q, beat_d;
  logic [10:0]       owed_q, owed_d;
  logic              sof_pend_q, sof_pend_d;
  logic              done_q, done_d;

  logic              word_gate;
  logic              pk_in_valid;
  logic              pk_in_ready;
  logic              xfer;
  logic              w_acc;
  logic [ADDR_W:0]   next_addr;

  assign word_gate   = (state_q == W) && (owed_q != '0);
  assign pk_in_valid = word_gate && rd_vld;
  assign rd_en       = word_gate && pk_in_ready;
  assign xfer        = rd_en && rd_vld;
  assign w_acc       = m_wvalid && m_wready;
  assign next_addr   = {1'b0, addr_q} + ADDR_INC;

  assign m_awaddr   = addr_q;
  assign m_awlen    = awlen_of(BURST_LEN);
  assign m_awvalid  = (state_q == AW);
  assign m_wstrb    = '1;
  assign m_wlast    = (beat_q == 9'd1);
  assign m_bready   = (state_q == WB);
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);

  fifo_word_packer_32to128 u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (rd_data),
    .in_valid_i  (pk_in_valid),
    .in_ready_o  (pk_in_ready),
    .out_data_o  (m_wdata),
    .out_valid_o (m_wvalid),
    .out_ready_i (m_wready)
  );

  // Burst sequencing, counters, address walk and sof rewind.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    owed_d     = owed_q;
    sof_pend_d = sof_pend_q;
    done_d     = 1'b0;
    if (xfer)  owed_d = owed_q - 11'd1;
    if (w_acc) beat_d = beat_q - 9'd1;
    unique case (state_q)
      IDLE: begin
        if (sof_pend_q) begin
          addr_d     = BASE_ADDR;
          sof_pend_d = 1'b0;
        end else if (en) begin
          state_d = AW;
        end
      end
      AW: begin
        if (m_awready) begin
          state_d = W;
          beat_d  = BEATS_INIT;
          owed_d  = WORDS_INIT;
        end
      end
      W: begin
        if (w_acc && m_wlast) state_d = WB;
      end
      WB: begin
        if (m_bvalid) begin
          state_d = IDLE;
          if (next_addr == END_ADDR) begin
            addr_d = BASE_ADDR;
            done_d = 1'b1;
          end else begin
            addr_d = next_addr[ADDR_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (sof) sof_pend_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= BASE_ADDR;
      beat_q     <= '0;
      owed_q     <= '0;
      sof_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      owed_q     <= owed_d;
      sof_pend_q <= sof_pend_d;
      done_q     <= done_d;
    end
  end

endmodule
